tx_block: RTL and testbench

UART-style serial transmitter, the upstream stage that produces the serial_in stream consumed by rcv_block. It accepts parallel bytes through a one-entry holding register and shifts each out as a frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT clocks, matching the receiver's nominal 10-clock bit period. Double buffering allows back-to-back frames with no idle gap.

---
 rtl/tx_pkg.sv | 15 +
 rtl/tx_bit_timer.sv | 34 +++
 rtl/tx_block.sv | 128 ++++++++++++
 tb/tb_tx_block.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and line levels for the UART-style transmitter.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the wrap.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign bit_done = enable && !clear && (count == LAST);

  // Free-running wrap counter while enabled; clear forces the count back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_block.sv
// Serial transmitter: one-entry holding register feeding a start/8-data/stop
// shifter, so a new byte can be queued while the current frame is on the line.
module tx_block
  import tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_write,
  input  logic                 clear_error,
  output logic                 tx_ready,
  output logic                 tx_active,
  output logic                 serial_out,
  output logic                 write_error
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] holding;
  logic                 holding_full;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 bit_done;
  logic                 accept;
  logic                 load;

  // The transfer cycle still reports the holding register as full, so a
  // write there is rejected; accept and load can never coincide.
  assign accept    = tx_write && !holding_full;
  assign load      = holding_full && ((state == IDLE) || ((state == STOP) && bit_done));
  assign tx_ready  = !holding_full;
  assign tx_active = (state != IDLE);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .bit_done(bit_done)
  );

  // Holding register: filled by an accepted write, emptied when the shifter loads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holding      <= '0;
      holding_full <= 1'b0;
    end else if (accept) begin
      holding      <= tx_data;
      holding_full <= 1'b1;
    end else if (load) begin
      holding_full <= 1'b0;
    end
  end

  // Frame sequencer driving the registered serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      serial_out <= IDLE_LEVEL;
    end else begin
      case (state)
        IDLE: begin
          if (holding_full) begin
            state      <= START;
            shift      <= holding;
            serial_out <= START_BIT;
          end
        end
        START: begin
          if (bit_done) begin
            state      <= DATA;
            serial_out <= shift[0];
            bit_idx    <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
              state      <= STOP;
              serial_out <= STOP_BIT;
            end else begin
              shift      <= shift >> 1;
              serial_out <= shift[1];
              bit_idx    <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            if (holding_full) begin
              state      <= START;
              shift      <= holding;
              serial_out <= START_BIT;
            end else begin
              state      <= IDLE;
              serial_out <= IDLE_LEVEL;
            end
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= IDLE_LEVEL;
        end
      endcase
    end
  end

  // Sticky error for writes that arrive while the holding register is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_error <= 1'b0;
    end else if (tx_write && holding_full) begin
      write_error <= 1'b1;
    end else if (clear_error) begin
      write_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_block.sv
// Bench for tx_block: accepted bytes go into a scoreboard queue, and an
// independent line decoder pops and compares each frame it sees.
module tb_tx_block;

  localparam int CPB = 10;

  logic       tb_clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       clear_error;
  logic       tx_ready;
  logic       tx_active;
  logic       serial_out;
  logic       write_error;

  int num_compared   = 0;
  int num_mismatched = 0;

  logic [7:0] exp_q[$];

  int         cycle_cnt   = 0;
  bit         mon_busy    = 0;
  int         mon_cnt     = 0;
  int         mon_bad     = 0;
  logic [7:0] mon_rx      = 8'h00;
  logic [7:0] mon_exp     = 8'h00;
  bit         mon_has     = 0;
  int         start_prev  = 0;
  int         start_last  = 0;

  tx_block #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_write   (tx_write),
    .clear_error(clear_error),
    .tx_ready   (tx_ready),
    .tx_active  (tx_active),
    .serial_out (serial_out),
    .write_error(write_error)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic frameBit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    else if (i <= 8) return b[i-1];
    else return 1'b1;
  endfunction

  // Drive one cycle of inputs at a negedge; a write expected to be accepted
  // pushes its byte onto the scoreboard.
  task automatic applyStimulus(input logic [7:0] data, input bit wr, input bit clr, input bit exp_ready);
    tx_data     = data;
    tx_write    = wr;
    clear_error = clr;
    checkOutput("tx_ready_at_write", {31'd0, tx_ready}, {31'd0, exp_ready});
    if (wr && exp_ready) exp_q.push_back(data);
    @(negedge tb_clk);
    tx_write    = 1'b0;
    clear_error = 1'b0;
  endtask

  // Wait (bounded) until every queued byte has been seen on the line, then
  // confirm the transmitter has gone idle.
  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !mon_busy) break;
      @(negedge tb_clk);
    end
    checkOutput("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge tb_clk);
    checkOutput("idle_active", {31'd0, tx_active}, 32'd0);
    checkOutput("idle_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("idle_line", {31'd0, serial_out}, 32'd1);
  endtask

  // Line decoder: detect a start bit, compare every cycle of the frame to the
  // expected waveform, sample mid-bit, and score the byte at the stop bit.
  always @(negedge tb_clk) begin
    cycle_cnt++;
    if (rst) begin
      mon_busy = 0;
    end else begin
      if (!mon_busy && serial_out == 1'b0) begin
        mon_busy   = 1;
        mon_cnt    = 0;
        mon_bad    = 0;
        mon_rx     = 8'h00;
        start_prev = start_last;
        start_last = cycle_cnt;
        mon_has    = (exp_q.size() != 0);
        checkOutput("frame_expected", {31'd0, mon_has}, 32'd1);
        mon_exp    = mon_has ? exp_q[0] : 8'h00;
      end else if (mon_busy) begin
        mon_cnt++;
      end
      if (mon_busy) begin
        if (serial_out !== frameBit(mon_exp, mon_cnt / CPB)) mon_bad++;
        if ((mon_cnt % CPB) == (CPB / 2) && (mon_cnt / CPB) >= 1 && (mon_cnt / CPB) <= 8)
          mon_rx[(mon_cnt / CPB) - 1] = serial_out;
        if (mon_cnt == 10 * CPB - 1) begin
          if (mon_has) void'(exp_q.pop_front());
          checkOutput("rx_data", {24'd0, mon_rx}, {24'd0, mon_exp});
          checkOutput("frame_shape", mon_bad, 0);
          mon_busy = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi_cnt;
    int act_cnt;
    int rdy_cnt;

    rst         = 1'b1;
    tx_data     = 8'h00;
    tx_write    = 1'b0;
    clear_error = 1'b0;
    repeat (3) @(negedge tb_clk);
    checkOutput("rst_line", {31'd0, serial_out}, 32'd1);
    checkOutput("rst_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("rst_active", {31'd0, tx_active}, 32'd0);
    checkOutput("rst_error", {31'd0, write_error}, 32'd0);
    rst = 1'b0;
    @(negedge tb_clk);

    // Single frame, with start latency and frame length checks.
    $display("[TB] single frame 0xD5");
    applyStimulus(8'hD5, 1, 0, 1);
    checkOutput("pre_start_line", {31'd0, serial_out}, 32'd1);
    @(negedge tb_clk);
    checkOutput("start_line", {31'd0, serial_out}, 32'd0);
    checkOutput("start_active", {31'd0, tx_active}, 32'd1);
    checkOutput("transfer_done_ready", {31'd0, tx_ready}, 32'd1);
    repeat (99) @(negedge tb_clk);
    checkOutput("stop_active", {31'd0, tx_active}, 32'd1);
    @(negedge tb_clk);
    checkOutput("end_active", {31'd0, tx_active}, 32'd0);
    waitDrain(50);

    // Back-to-back frames with no idle gap.
    $display("[TB] back-to-back 0x55, 0xA3");
    applyStimulus(8'h55, 1, 0, 1);
    checkOutput("transfer_ready", {31'd0, tx_ready}, 32'd0);
    @(negedge tb_clk);
    applyStimulus(8'hA3, 1, 0, 1);
    waitDrain(400);
    checkOutput("b2b_gap", start_last - start_prev, 10 * CPB);

    // Writes on consecutive cycles: the middle one lands in the transfer cycle.
    $display("[TB] consecutive writes 0x11, 0x22, 0x33");
    applyStimulus(8'h11, 1, 0, 1);
    applyStimulus(8'h22, 1, 0, 0);
    applyStimulus(8'h33, 1, 0, 1);
    checkOutput("error_set", {31'd0, write_error}, 32'd1);
    applyStimulus(8'h00, 0, 1, 0);
    checkOutput("error_cleared", {31'd0, write_error}, 32'd0);
    applyStimulus(8'h44, 1, 1, 0);
    checkOutput("error_set_wins", {31'd0, write_error}, 32'd1);
    applyStimulus(8'h00, 0, 1, 0);
    checkOutput("error_cleared_again", {31'd0, write_error}, 32'd0);
    waitDrain(400);

    // Reset in the middle of a frame, then a clean frame afterwards.
    $display("[TB] mid-frame reset during 0xFF");
    applyStimulus(8'hFF, 1, 0, 1);
    applyStimulus(8'hEE, 1, 0, 0);
    checkOutput("pre_reset_error", {31'd0, write_error}, 32'd1);
    repeat (34) @(negedge tb_clk);
    checkOutput("pre_reset_active", {31'd0, tx_active}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_line", {31'd0, serial_out}, 32'd1);
    checkOutput("async_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("async_active", {31'd0, tx_active}, 32'd0);
    checkOutput("async_error", {31'd0, write_error}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge tb_clk);
    rst = 1'b0;
    @(negedge tb_clk);
    applyStimulus(8'h3C, 1, 0, 1);
    waitDrain(200);

    // Long idle: line stays high, nothing active.
    $display("[TB] idle 200 cycles");
    hi_cnt  = 0;
    act_cnt = 0;
    rdy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge tb_clk);
      if (serial_out === 1'b1) hi_cnt++;
      if (tx_active !== 1'b0) act_cnt++;
      if (tx_ready === 1'b1) rdy_cnt++;
    end
    checkOutput("idle_hi_cycles", hi_cnt, 200);
    checkOutput("idle_active_cycles", act_cnt, 0);
    checkOutput("idle_ready_cycles", rdy_cnt, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
